dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_if.sv | 22 ++
 rtl/dmem_responder.sv | 134 +++++++++++++
 tb/tb_dmem_responder.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Processor data-memory request/response bus between a load/store initiator
// and the dmem_responder storage model.
interface dmem_responder_if;
   logic [31:0] ip_data_addr;
   logic        ip_data_wr;
   logic [3:0]  ip_data_mask;
   logic [31:0] ip_data_from_proc;
   logic        ip_data_rd;
   logic        op_data_valid;
   logic [31:0] op_data_to_proc;
   logic        op_busy;

   modport master (
      output ip_data_addr, ip_data_wr, ip_data_mask, ip_data_from_proc, ip_data_rd,
      input  op_data_valid, op_data_to_proc, op_busy
   );

   modport slave (
      input  ip_data_addr, ip_data_wr, ip_data_mask, ip_data_from_proc, ip_data_rd,
      output op_data_valid, op_data_to_proc, op_busy
   );
endinterface

// File: rtl/dmem_responder.sv
// Byte-maskable word storage answering one request at a time with a fixed
// response latency; writes and read captures happen on the acceptance edge.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic             clk,
   input  logic             reset,
   dmem_responder_if.slave  bus
);

   localparam int         AW          = $clog2(DEPTH_WORDS);
   localparam bit         DIRECT_RESP = (LATENCY == 1);
   localparam logic [3:0] LAT_LOAD    = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_next_s;
   logic [3:0]      cnt_r;
   logic [3:0]      cnt_next_s;
   logic            accept_s;
   logic            is_write_s;
   logic [AW-1:0]   idx_s;
   logic [31:0]     accept_word_s;
   logic [31:0]     resp_word_r;
   logic            valid_r;
   logic            busy_r;
   logic [31:0]     data_r;
   logic [31:0]     mem_r [DEPTH_WORDS];
   logic            unused_addr_bits_s;

   assign accept_s           = (state_r == IDLE) && (bus.ip_data_rd || bus.ip_data_wr);
   assign is_write_s         = bus.ip_data_wr;
   assign idx_s              = bus.ip_data_addr[AW+1:2];
   assign unused_addr_bits_s = ^{bus.ip_data_addr[31:AW+2], bus.ip_data_addr[1:0]};

   // Response word chosen at acceptance: read data, or zero for any write.
   always_comb begin
      accept_word_s = 32'd0;
      if (is_write_s) begin
         accept_word_s = 32'd0;
      end else begin
         accept_word_s = mem_r[idx_s];
      end
   end

   // Next-state and counter logic; the counter paces the BUSY wait.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (DIRECT_RESP) begin
                  state_next_s = RESP;
                  cnt_next_s   = 4'd0;
               end else begin
                  state_next_s = BUSY;
                  cnt_next_s   = LAT_LOAD;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         BUSY: begin
            if (cnt_r == 4'd1) begin
               state_next_s = RESP;
               cnt_next_s   = 4'd0;
            end else begin
               cnt_next_s   = cnt_r - 4'd1;
            end
         end
         RESP: begin
            state_next_s = IDLE;
         end
         default: begin
            state_next_s = IDLE;
            cnt_next_s   = 4'd0;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
      end
   end

   // Registered outputs, derived from the state being entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_r     <= 1'b0;
         busy_r      <= 1'b0;
         data_r      <= 32'd0;
         resp_word_r <= 32'd0;
      end else begin
         valid_r <= (state_next_s == RESP);
         busy_r  <= (state_next_s != IDLE);
         if (accept_s) begin
            resp_word_r <= accept_word_s;
         end
         // With a one-edge latency the response is loaded straight from the acceptance word.
         if (state_next_s == RESP) begin
            data_r <= (state_r == IDLE) ? accept_word_s : resp_word_r;
         end
      end
   end

   // Storage is never reset; masked byte lanes are written on acceptance.
   always_ff @(posedge clk) begin
      if (accept_s && is_write_s) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.ip_data_mask[i]) begin
               mem_r[idx_s][8*i +: 8] <= bus.ip_data_from_proc[8*i +: 8];
            end
         end
      end
   end

   assign bus.op_data_valid   = valid_r;
   assign bus.op_busy         = busy_r;
   assign bus.op_data_to_proc = data_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed checks of dmem_responder against a word-array model
// that tracks which byte lanes have been written.
module tb_dmem_responder;

   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fails;

   logic [31:0] ref_mem   [DEPTH];
   logic [3:0]  ref_known [DEPTH];

   dmem_responder_if bus ();

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int word_of(input logic [31:0] a);
      return int'((a / 32'd4) % DEPTH);
   endfunction

   function automatic logic [31:0] lanes_of(input logic [3:0] m);
      return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
   endfunction

   function automatic void model_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
      int w;
      w = word_of(a);
      ref_mem[w]   = (ref_mem[w] & ~lanes_of(m)) | (d & lanes_of(m));
      ref_known[w] = ref_known[w] | m;
   endfunction

   // Issue one request; lat counts edges from acceptance (edge 1) to the edge after which valid is seen.
   task automatic do_req(input bit w, input bit r, input logic [31:0] a, input logic [3:0] m,
                         input logic [31:0] d, output logic [31:0] got, output int lat,
                         output bit after_valid, output bit after_busy, output logic [31:0] after_data);
      @(negedge clk);
      bus.ip_data_wr        = w;
      bus.ip_data_rd        = r;
      bus.ip_data_addr      = a;
      bus.ip_data_mask      = m;
      bus.ip_data_from_proc = d;
      lat = 0;
      got = 32'd0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         @(posedge clk);
         #1;
         if (bus.op_data_valid === 1'b1) begin
            lat = k;
            got = bus.op_data_to_proc;
         end
      end
      bus.ip_data_wr = 1'b0;
      bus.ip_data_rd = 1'b0;
      @(posedge clk);
      #1;
      after_valid = bus.op_data_valid;
      after_busy  = bus.op_busy;
      after_data  = bus.op_data_to_proc;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.op_data_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL reset_valid: got %b want 0", bus.op_data_valid);
      end
      n_checks++;
      if (bus.op_busy !== 1'b0) begin
         n_fails++;
         $display("FAIL reset_busy: got %b want 0", bus.op_busy);
      end
      n_checks++;
      if (bus.op_data_to_proc !== 32'd0) begin
         n_fails++;
         $display("FAIL reset_data: got %h want 0", bus.op_data_to_proc);
      end
      reset = 1'b0;
   endtask

   task automatic test_directed;
      logic [31:0] got, ad, exp;
      int lat;
      bit av, ab;
      // kind: 1=write 0=read 2=both; each row {kind, addr, mask, data}
      int          kinds [10] = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 2};
      logic [31:0] addrs [10] = '{32'h10, 32'h10, 32'h10, 32'h10, 32'h10, 32'h10,
                                  32'h400, 32'h000, 32'h403, 32'h20};
      logic [3:0]  masks [10] = '{4'hF, 4'hF, 4'h1, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h1};
      logic [31:0] datas [10] = '{32'hDEADBEEF, 32'h0, 32'h000000AA, 32'h0, 32'hFFFFFFFF,
                                  32'h0, 32'h12345678, 32'h0, 32'h0, 32'h00000055};
      logic [31:0] want  [10] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEAA, 32'h0,
                                  32'hDEADBEAA, 32'h0, 32'h12345678, 32'h12345678, 32'h0};
      for (int i = 0; i < 10; i++) begin
         do_req(kinds[i] != 0, kinds[i] != 1, addrs[i], masks[i], datas[i], got, lat, av, ab, ad);
         if (kinds[i] != 0) model_write(addrs[i], masks[i], datas[i]);
         n_checks++;
         if (lat != LAT) begin
            n_fails++;
            $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, LAT);
         end
         n_checks++;
         if (got !== want[i]) begin
            n_fails++;
            $display("FAIL dir_data[%0d]: got %h want %h", i, got, want[i]);
         end
         n_checks++;
         if (av !== 1'b0 || ab !== 1'b0) begin
            n_fails++;
            $display("FAIL dir_pulse_end[%0d]: valid %b busy %b want 0 0", i, av, ab);
         end
      end
      // Lane 0 was written with 0x55 by the combined request at 0x20.
      do_req(1'b0, 1'b1, 32'h20, 4'h0, 32'h0, got, lat, av, ab, ad);
      exp = ref_mem[word_of(32'h20)];
      n_checks++;
      if ((got & 32'hFF) !== 32'h55 || (got & lanes_of(ref_known[8])) !== (exp & lanes_of(ref_known[8]))) begin
         n_fails++;
         $display("FAIL dir_both_readback: got %h want low byte 55", got);
      end
   endtask

   task automatic test_random;
      logic [31:0] got, ad, a, d, exp, km;
      logic [3:0]  m;
      int lat, kind, idx;
      bit av, ab;
      for (int i = 0; i < 16; i++) begin
         d = $urandom;
         do_req(1'b1, 1'b0, 32'(i * 4), 4'hF, d, got, lat, av, ab, ad);
         model_write(32'(i * 4), 4'hF, d);
      end
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 2);
         idx  = $urandom_range(0, 15);
         a    = ($urandom & 32'hFFFF_FC03) | 32'(idx * 4);
         m    = 4'($urandom);
         d    = $urandom;
         exp  = (kind == 0) ? ref_mem[word_of(a)] : 32'd0;
         km   = (kind == 0) ? lanes_of(ref_known[word_of(a)]) : 32'hFFFF_FFFF;
         do_req(kind != 0, kind != 1, a, m, d, got, lat, av, ab, ad);
         if (kind != 0) model_write(a, m, d);
         n_checks++;
         if (lat != LAT || (got & km) !== (exp & km)) begin
            n_fails++;
            $display("FAIL rand[%0d]: kind %0d addr %h lat %0d data %h want lat %0d data %h",
                     n, kind, a, lat, got, LAT, exp);
         end
         n_checks++;
         if (av !== 1'b0 || ab !== 1'b0 || ad !== got) begin
            n_fails++;
            $display("FAIL rand_hold[%0d]: valid %b busy %b data %h want 0 0 %h", n, av, ab, ad, got);
         end
      end
   endtask

   task automatic test_back_to_back;
      bit exp_v, exp_b;
      logic [31:0] exp_d;
      exp_d = ref_mem[word_of(32'h10)];
      @(negedge clk);
      bus.ip_data_rd   = 1'b1;
      bus.ip_data_wr   = 1'b0;
      bus.ip_data_addr = 32'h10;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         exp_v = ((k - 1) % (LAT + 1)) == (LAT - 1);
         exp_b = ((k - 1) % (LAT + 1)) != LAT;
         n_checks++;
         if (bus.op_data_valid !== exp_v || bus.op_busy !== exp_b) begin
            n_fails++;
            $display("FAIL b2b_edge[%0d]: valid %b busy %b want %b %b",
                     k, bus.op_data_valid, bus.op_busy, exp_v, exp_b);
         end
         if (exp_v) begin
            n_checks++;
            if (bus.op_data_to_proc !== exp_d) begin
               n_fails++;
               $display("FAIL b2b_data[%0d]: got %h want %h", k, bus.op_data_to_proc, exp_d);
            end
         end
      end
      @(negedge clk);
      bus.ip_data_rd = 1'b0;
   endtask

   task automatic test_reset_mid_request;
      logic [31:0] got, ad;
      int lat, seen;
      bit av, ab;
      do_req(1'b0, 1'b1, 32'h10, 4'h0, 32'h0, got, lat, av, ab, ad);
      @(negedge clk);
      bus.ip_data_wr        = 1'b1;
      bus.ip_data_addr      = 32'h30;
      bus.ip_data_mask      = 4'hF;
      bus.ip_data_from_proc = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.op_busy !== 1'b1) begin
         n_fails++;
         $display("FAIL mid_busy: got %b want 1", bus.op_busy);
      end
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (bus.op_data_valid !== 1'b0 || bus.op_busy !== 1'b0 || bus.op_data_to_proc !== 32'd0) begin
         n_fails++;
         $display("FAIL mid_reset_async: valid %b busy %b data %h want 0 0 0",
                  bus.op_data_valid, bus.op_busy, bus.op_data_to_proc);
      end
      @(negedge clk);
      reset          = 1'b0;
      bus.ip_data_wr = 1'b0;
      model_write(32'h30, 4'hF, 32'hCAFEF00D);
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         if (bus.op_data_valid === 1'b1) seen++;
      end
      n_checks++;
      if (seen != 0) begin
         n_fails++;
         $display("FAIL mid_no_pulse: got %0d pulses want 0", seen);
      end
      do_req(1'b0, 1'b1, 32'h30, 4'h0, 32'h0, got, lat, av, ab, ad);
      n_checks++;
      if (got !== ref_mem[word_of(32'h30)] || lat != LAT) begin
         n_fails++;
         $display("FAIL mid_readback: got %h lat %0d want %h lat %0d", got, lat, ref_mem[word_of(32'h30)], LAT);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      for (int i = 0; i < DEPTH; i++) begin
         ref_mem[i]   = 32'd0;
         ref_known[i] = 4'h0;
      end
      bus.ip_data_addr      = 32'd0;
      bus.ip_data_wr        = 1'b0;
      bus.ip_data_mask      = 4'h0;
      bus.ip_data_from_proc = 32'd0;
      bus.ip_data_rd        = 1'b0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_mid_request();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
